// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the Maxnet winner-take-all engine.
// Holds the FSM state encoding, default Q-format constants and the ReLU clamp.
package maxnet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUM,
        UPDATE,
        CHECK,
        FIN
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_FRAC_W   = 8;
    localparam int DEF_MAX_ITER = 64;

    // Wide enough for any intermediate of the default and moderately larger configurations.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int sum_width(input int n, input int data_w);
        return data_w + $clog2(n);
    endfunction

    function automatic wide_t relu(input wide_t x);
        return (x < 0) ? '0 : x;
    endfunction

endpackage

// File: rtl/maxnet_update_pe.sv
// Combinational Maxnet update: a' = relu(a - floor(eps*(S - a) / 2^FRAC_W)).
// Shared by all channels; the engine feeds one channel per cycle.
module maxnet_update_pe
    import maxnet_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int SUM_W  = sum_width(DEF_N, DEF_DATA_W)
) (
    input  logic signed [DATA_W-1:0] a_k,
    input  logic signed [SUM_W-1:0]  s,
    input  logic signed [DATA_W-1:0] eps,
    output logic signed [DATA_W-1:0] a_next
);

    localparam int PROD_W = DATA_W + SUM_W;

    logic signed [SUM_W:0]    diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] p;

    assign diff = (SUM_W+1)'(s) - (SUM_W+1)'(a_k);
    assign prod = PROD_W'(eps) * PROD_W'(diff);
    // Arithmetic shift rounds toward minus infinity, matching the floor in the update rule.
    assign p    = prod >>> FRAC_W;

    // a_k > p keeps the difference, otherwise the channel is silenced.
    assign a_next = DATA_W'(relu(wide_t'(a_k) - wide_t'(p)));

endmodule

// File: rtl/maxnet_engine.sv
// Parametrised Maxnet winner-take-all engine with one time-multiplexed update PE.
// Optional iteration-count output enabled by defining MAXNET_ITER_OUT_EN.
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N*DATA_W-1:0]          a_init,
    input  logic [DATA_W-1:0]            epsilon,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N)-1:0]         winner_idx,
    output logic [DATA_W-1:0]            winner_val,
    output logic                         no_winner,
    output logic                         timeout
`ifdef MAXNET_ITER_OUT_EN
    ,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
`endif
);

    localparam int IDX_W  = $clog2(N);
    localparam int SUM_W  = sum_width(N, DATA_W);
    localparam int CNT_W  = $clog2(N + 1);
    localparam int ITER_W = $clog2(MAX_ITER + 1);

    localparam logic [IDX_W-1:0]  LAST_K     = IDX_W'(N - 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    state_t state, state_next;

    logic signed [DATA_W-1:0] a_reg [N];
    logic signed [DATA_W-1:0] eps_reg;
    logic signed [SUM_W-1:0]  s_acc;
    logic [IDX_W-1:0]         k;
    logic [ITER_W-1:0]        iter;
    logic [CNT_W-1:0]         nz_cnt;
    logic [IDX_W-1:0]         nz_idx;
    logic [IDX_W-1:0]         best_idx;
    logic signed [DATA_W-1:0] best_val;

    logic signed [DATA_W-1:0] a_cur;
    logic signed [DATA_W-1:0] a_next;
    logic [ITER_W-1:0]        iter_inc;
    logic                     last_k;
    logic                     chk_single;
    logic                     chk_none;
    logic                     chk_limit;
    logic                     chk_done;

    assign a_cur = a_reg[k];

    maxnet_update_pe #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .SUM_W  (SUM_W)
    ) u_pe (
        .a_k    (a_cur),
        .s      (s_acc),
        .eps    (eps_reg),
        .a_next (a_next)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        last_k     = (k == LAST_K);
        iter_inc   = iter + ITER_W'(1);
        chk_single = (nz_cnt == CNT_W'(1));
        chk_none   = (nz_cnt == '0);
        chk_limit  = (iter_inc == ITER_LIMIT);
        chk_done   = chk_single || chk_none || chk_limit;

        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SUM;
            SUM:     if (last_k) state_next = UPDATE;
            UPDATE:  if (last_k) state_next = CHECK;
            CHECK:   state_next = chk_done ? FIN : SUM;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            winner_idx <= '0;
            winner_val <= '0;
            no_winner  <= 1'b0;
            timeout    <= 1'b0;
            // NOTE: the activation file is reset explicitly; it is small and its cleared state is observable.
            for (int i = 0; i < N; i++) a_reg[i] <= '0;
            eps_reg    <= '0;
            s_acc      <= '0;
            k          <= '0;
            iter       <= '0;
            nz_cnt     <= '0;
            nz_idx     <= '0;
            best_idx   <= '0;
            best_val   <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) a_reg[i] <= a_init[i*DATA_W +: DATA_W];
                        eps_reg   <= epsilon;
                        no_winner <= 1'b0;
                        timeout   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                LOAD: begin
                    for (int i = 0; i < N; i++) a_reg[i] <= DATA_W'(relu(wide_t'(a_reg[i])));
                    iter  <= '0;
                    s_acc <= '0;
                    k     <= '0;
                end

                SUM: begin
                    s_acc <= s_acc + SUM_W'(a_cur);
                    k     <= last_k ? '0 : k + IDX_W'(1);
                    if (last_k) begin
                        nz_cnt   <= '0;
                        best_idx <= '0;
                        best_val <= '0;
                    end
                end

                UPDATE: begin
                    a_reg[k] <= a_next;
                    if (a_next != '0) begin
                        nz_cnt <= nz_cnt + CNT_W'(1);
                        nz_idx <= k;
                    end
                    // Strict compare keeps the lowest index on ties.
                    if (a_next > best_val) begin
                        best_val <= a_next;
                        best_idx <= k;
                    end
                    k <= last_k ? '0 : k + IDX_W'(1);
                end

                CHECK: begin
                    iter  <= iter_inc;
                    s_acc <= '0;
                    if (chk_done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    if (chk_single) begin
                        winner_idx <= nz_idx;
                        winner_val <= best_val;
                    end else if (chk_none) begin
                        no_winner  <= 1'b1;
                        winner_idx <= '0;
                        winner_val <= '0;
                    end else if (chk_limit) begin
                        timeout    <= 1'b1;
                        winner_idx <= best_idx;
                        winner_val <= best_val;
                    end
                end

                default: ;
            endcase
        end
    end

`ifdef MAXNET_ITER_OUT_EN
    assign iter_count = iter;
`endif

endmodule

// File: tb/tb_maxnet_engine.sv
// Directed, table-driven bench for maxnet_engine (N=4, Q8.8, MAX_ITER=16).
// Adds hand-written sequences for start-while-busy and mid-run reset.
module tb_maxnet_engine;

    localparam int N      = 4;
    localparam int DW     = 16;
    localparam int FW     = 8;
    localparam int MI     = 16;
    localparam int IW     = $clog2(MI + 1);
    localparam int BUDGET = 400;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [N*DW-1:0]     a_init;
    logic [DW-1:0]       epsilon;
    logic                busy;
    logic                done;
    logic [$clog2(N)-1:0] winner_idx;
    logic [DW-1:0]       winner_val;
    logic                no_winner;
    logic                timeout;
`ifdef MAXNET_ITER_OUT_EN
    logic [IW-1:0]       iter_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maxnet_engine #(
        .N        (N),
        .DATA_W   (DW),
        .FRAC_W   (FW),
        .MAX_ITER (MI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_init     (a_init),
        .epsilon    (epsilon),
        .busy       (busy),
        .done       (done),
        .winner_idx (winner_idx),
        .winner_val (winner_val),
        .no_winner  (no_winner),
        .timeout    (timeout)
`ifdef MAXNET_ITER_OUT_EN
        ,
        .iter_count (iter_count)
`endif
    );

    typedef struct {
        string           name;
        logic [N*DW-1:0] a;
        logic [DW-1:0]   eps;
        int              idx;
        logic [DW-1:0]   val;
        bit              nw;
        bit              to;
        int              iters;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [N*DW-1:0] pack4(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                              input logic [DW-1:0] a2, input logic [DW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drives start for one cycle; returns at the falling edge of the LOAD cycle.
    task automatic do_start(input logic [N*DW-1:0] a, input logic [DW-1:0] e);
        @(negedge clk);
        a_init  = a;
        epsilon = e;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Cycle numbering counts the start cycle as 1, so the LOAD cycle is 2.
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (done !== 1'b1 && cyc < cyc0 + BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_results(input vec_t v, input int cyc);
        check({v.name, "_idx"},     64'(winner_idx), 64'(v.idx));
        check({v.name, "_val"},     64'(winner_val), 64'(v.val));
        check({v.name, "_nw"},      64'(no_winner),  64'(v.nw));
        check({v.name, "_to"},      64'(timeout),    64'(v.to));
        check({v.name, "_latency"}, 64'(cyc),        64'(2 + v.iters * (2 * N + 1) + 1));
        check({v.name, "_busy_at_done"}, 64'(busy),  64'd0);
`ifdef MAXNET_ITER_OUT_EN
        check({v.name, "_iters"},   64'(iter_count), 64'(v.iters));
`endif
        @(negedge clk);
        check({v.name, "_done_pulse"}, 64'(done),    64'd0);
        check({v.name, "_hold_val"},   64'(winner_val), 64'(v.val));
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        do_start(v.a, v.eps);
        check({v.name, "_busy"}, 64'(busy), 64'd1);
        wait_done(2, cyc);
        check_results(v, cyc);
    endtask

    initial begin
        int cyc;
        int pulses;

        rst     = 1'b1;
        start   = 1'b0;
        a_init  = '0;
        epsilon = '0;

        vecs[0] = '{"t1_decay",  pack4(16'h0099, 16'h0080, 16'h004D, 16'h001A), 16'h0033, 0, 16'h0043, 1'b0, 1'b0, 6};
        vecs[1] = '{"t2_single", pack4(16'h0000, 16'h0000, 16'h0100, 16'h0000), 16'h0033, 2, 16'h0100, 1'b0, 1'b0, 1};
        vecs[2] = '{"t3_zero",   pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h0033, 0, 16'h0000, 1'b1, 1'b0, 1};
        vecs[3] = '{"t4_stall",  pack4(16'h0080, 16'h0080, 16'h0080, 16'h0080), 16'h0040, 0, 16'h0001, 1'b0, 1'b1, MI};
        vecs[4] = '{"t5_clamp",  pack4(16'hFF00, 16'h0040, 16'h0000, 16'h0000), 16'h0033, 1, 16'h0040, 1'b0, 1'b0, 1};
        vecs[5] = '{"eps_one",   pack4(16'h0100, 16'h00C0, 16'h0000, 16'h0000), 16'h0100, 0, 16'h0040, 1'b0, 1'b0, 1};
        vecs[6] = '{"eps_tie0",  pack4(16'h0080, 16'h0080, 16'h0000, 16'h0000), 16'h0100, 0, 16'h0000, 1'b1, 1'b0, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy),       64'd0);
        check("rst_done", 64'(done),       64'd0);
        check("rst_idx",  64'(winner_idx), 64'd0);
        check("rst_val",  64'(winner_val), 64'd0);
        check("rst_nw",   64'(no_winner),  64'd0);
        check("rst_to",   64'(timeout),    64'd0);
`ifdef MAXNET_ITER_OUT_EN
        check("rst_iters", 64'(iter_count), 64'd0);
`endif

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Start pulse with different data in the middle of UPDATE must be ignored.
        do_start(vecs[0].a, vecs[0].eps);
        cyc = 2;
        repeat (5) begin
            @(negedge clk);
            cyc++;
        end
        a_init  = vecs[1].a;
        epsilon = vecs[1].eps;
        start   = 1'b1;
        @(negedge clk);
        cyc++;
        start   = 1'b0;
        check("upd_start_busy", 64'(busy), 64'd1);
        wait_done(cyc, cyc);
        check_results(vecs[0], cyc);

        // Reset during SUM clears everything on the next cycle and suppresses done.
        do_start(vecs[0].a, vecs[0].eps);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy),       64'd0);
        check("midrst_done", 64'(done),       64'd0);
        check("midrst_idx",  64'(winner_idx), 64'd0);
        check("midrst_val",  64'(winner_val), 64'd0);
        check("midrst_nw",   64'(no_winner),  64'd0);
        check("midrst_to",   64'(timeout),    64'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);

        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
